uart_job_dispatcher: RTL and testbench

Initiator end of the miner's byte-framed UART protocol; the miner-side comm block is the responder. Serializes a mining job (PUSH_JOB) or an info request (INFO) into a framed packet and drives it byte by byte into the `uart` core. It then waits for the ACK/INVALID/INFO response with a timeout. Unsolicited NONCE packets are reported whenever they arrive. It sits in the host/controller FPGA, between job-generation logic and the `uart` core.

---
 rtl/uart_proto_pkg.sv | 38 +++
 rtl/uart_frame_rx.sv | 81 ++++++++
 rtl/uart_job_dispatcher.sv | 179 +++++++++++++++++
 tb/tb_uart_job_dispatcher.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_proto_pkg.sv
// Shared constants for the miner byte-framed UART protocol: type codes, frame
// lengths, FSM state encodings and the request frame builder.
package uart_proto_pkg;

   localparam int unsigned FRAME_W  = 480;
   localparam int unsigned JOB_SIZE = 416;

   localparam logic [7:0] MSG_INFO     = 8'd0;
   localparam logic [7:0] MSG_INVALID  = 8'd1;
   localparam logic [7:0] MSG_PUSH_JOB = 8'd2;
   localparam logic [7:0] MSG_NONCE    = 8'd3;
   localparam logic [7:0] MSG_ACK      = 8'd4;

   localparam logic [7:0] LEN_PUSH_JOB = 8'd60;
   localparam logic [7:0] LEN_INFO_REQ = 8'd8;
   localparam logic [7:0] LEN_INFO_RSP = 8'd16;
   localparam logic [7:0] LEN_NONCE    = 8'd12;
   localparam logic [7:0] LEN_ACK      = 8'd8;
   localparam logic [7:0] LEN_RX_MIN   = 8'd8;
   localparam logic [7:0] LEN_RX_MAX   = 8'd16;

   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_e;
   typedef enum logic [1:0] {RX_LEN, RX_BODY, RX_SKIP} rx_state_e;

   // Request frame, left-aligned so bytes leave from the top of the register.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic         is_push,
      input logic [255:0] midstate,
      input logic [95:0]  data,
      input logic [31:0]  nonce_min,
      input logic [31:0]  nonce_max
   );
      if (is_push)
         return {LEN_PUSH_JOB, 16'h0000, MSG_PUSH_JOB, midstate, data, nonce_min, nonce_max, 32'h0};
      return {LEN_INFO_REQ, 16'h0000, MSG_INFO, 32'h0, {JOB_SIZE{1'b0}}};
   endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// Byte-to-frame parser. frame_valid and payload are presented together with the
// final byte of a frame so the consumer can register its reaction one cycle later.
module uart_frame_rx
   import uart_proto_pkg::*;
(
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        received,
   input  logic [7:0]  rx_byte,
   output logic        frame_valid,
   output logic [7:0]  frame_type,
   output logic [7:0]  frame_len,
   output logic [63:0] payload
);

   rx_state_e   state, state_nxt;
   logic [7:0]  rem, rem_nxt;
   logic [7:0]  len_q, len_nxt;
   logic [7:0]  type_q, type_nxt;
   logic [63:0] shift_q, shift_nxt;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state   <= RX_LEN;
         rem     <= '0;
         len_q   <= '0;
         type_q  <= '0;
         shift_q <= '0;
      end else begin
         state   <= state_nxt;
         rem     <= rem_nxt;
         len_q   <= len_nxt;
         type_q  <= type_nxt;
         shift_q <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      rem_nxt     = rem;
      len_nxt     = len_q;
      type_nxt    = type_q;
      shift_nxt   = shift_q;
      frame_valid = 1'b0;
      if (received) begin
         case (state)
            RX_LEN: begin
               len_nxt   = rx_byte;
               rem_nxt   = rx_byte - 8'd1;
               shift_nxt = {shift_q[55:0], rx_byte};
               // Out-of-range lengths are skipped; 0 and 1 occupy only the length byte.
               if (rx_byte >= LEN_RX_MIN && rx_byte <= LEN_RX_MAX)
                  state_nxt = RX_BODY;
               else if (rx_byte > 8'd1)
                  state_nxt = RX_SKIP;
            end
            RX_BODY: begin
               shift_nxt = {shift_q[55:0], rx_byte};
               rem_nxt   = rem - 8'd1;
               if (len_q - rem == 8'd3)
                  type_nxt = rx_byte;
               if (rem == 8'd1) begin
                  frame_valid = 1'b1;
                  state_nxt   = RX_LEN;
               end
            end
            RX_SKIP: begin
               rem_nxt = rem - 8'd1;
               if (rem == 8'd1)
                  state_nxt = RX_LEN;
            end
            default: state_nxt = RX_LEN;
         endcase
      end
   end

   assign frame_type = type_q;
   assign frame_len  = len_q;
   assign payload    = {shift_q[55:0], rx_byte};

endmodule

// File: rtl/uart_job_dispatcher.sv
// Host-side initiator: frames PUSH_JOB / INFO requests into the uart core, then
// matches the response or times out. NONCE packets are reported at any time.
module uart_job_dispatcher
   import uart_proto_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
   input  logic         sys_clk,
   input  logic         rst,
   input  logic         req_push,
   input  logic         req_info,
   input  logic [255:0] job_midstate,
   input  logic [95:0]  job_data,
   input  logic [31:0]  job_nonce_min,
   input  logic [31:0]  job_nonce_max,
   output logic         transmit,
   output logic [7:0]   tx_byte,
   input  logic         is_transmitting,
   input  logic         received,
   input  logic [7:0]   rx_byte,
   output logic         busy,
   output logic         done,
   output logic         ack_ok,
   output logic         nak,
   output logic         timeout,
   output logic [63:0]  info_data,
   output logic         nonce_valid,
   output logic [31:0]  nonce
);

   tx_state_e          state, state_nxt;
   logic [FRAME_W-1:0] shreg, shreg_nxt;
   logic [5:0]         cnt, cnt_nxt;
   logic               guard, guard_nxt;
   logic               is_info, is_info_nxt;
   logic [23:0]        tcnt, tcnt_nxt;
   logic               transmit_nxt, busy_nxt, done_nxt;
   logic               ack_ok_nxt, nak_nxt, timeout_nxt, nonce_valid_nxt;
   logic [7:0]         tx_byte_nxt;
   logic [63:0]        info_data_nxt;
   logic [31:0]        nonce_nxt;
   logic               try_send;

   logic               frame_valid;
   logic [7:0]         frame_type, frame_len;
   logic [63:0]        payload;
   logic [FRAME_W-1:0] req_frame;
   logic               rsp_ok, is_nonce;

   uart_frame_rx u_rx (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .received    (received),
      .rx_byte     (rx_byte),
      .frame_valid (frame_valid),
      .frame_type  (frame_type),
      .frame_len   (frame_len),
      .payload     (payload)
   );

   assign req_frame = build_frame(req_push, job_midstate, job_data, job_nonce_min, job_nonce_max);
   assign is_nonce  = (frame_type == MSG_NONCE);
   assign rsp_ok    = is_info ? (frame_type == MSG_INFO && frame_len == LEN_INFO_RSP)
                              : (frame_type == MSG_ACK  && frame_len == LEN_ACK);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state       <= TX_IDLE;
         shreg       <= '0;
         cnt         <= '0;
         guard       <= 1'b0;
         is_info     <= 1'b0;
         tcnt        <= '0;
         transmit    <= 1'b0;
         tx_byte     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ack_ok      <= 1'b0;
         nak         <= 1'b0;
         timeout     <= 1'b0;
         info_data   <= '0;
         nonce_valid <= 1'b0;
         nonce       <= '0;
      end else begin
         state       <= state_nxt;
         shreg       <= shreg_nxt;
         cnt         <= cnt_nxt;
         guard       <= guard_nxt;
         is_info     <= is_info_nxt;
         tcnt        <= tcnt_nxt;
         transmit    <= transmit_nxt;
         tx_byte     <= tx_byte_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         ack_ok      <= ack_ok_nxt;
         nak         <= nak_nxt;
         timeout     <= timeout_nxt;
         info_data   <= info_data_nxt;
         nonce_valid <= nonce_valid_nxt;
         nonce       <= nonce_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      shreg_nxt       = shreg;
      cnt_nxt         = cnt;
      guard_nxt       = 1'b0;
      is_info_nxt     = is_info;
      tcnt_nxt        = tcnt;
      transmit_nxt    = 1'b0;
      tx_byte_nxt     = tx_byte;
      busy_nxt        = busy;
      done_nxt        = 1'b0;
      ack_ok_nxt      = 1'b0;
      nak_nxt         = 1'b0;
      timeout_nxt     = 1'b0;
      info_data_nxt   = info_data;
      nonce_valid_nxt = 1'b0;
      nonce_nxt       = nonce;
      try_send        = 1'b0;

      if (frame_valid && is_nonce && frame_len == LEN_NONCE) begin
         nonce_valid_nxt = 1'b1;
         nonce_nxt       = payload[31:0];
      end

      case (state)
         TX_IDLE: begin
            if (req_push || req_info) begin
               busy_nxt    = 1'b1;
               is_info_nxt = !req_push;
               shreg_nxt   = req_frame;
               cnt_nxt     = 6'(req_frame[FRAME_W-1 -: 8]);
               state_nxt   = TX_SEND;
               try_send    = !is_transmitting;
            end
         end
         TX_SEND: try_send = !is_transmitting && !guard;
         TX_WAIT: begin
            // A response completing on the last timeout cycle takes priority.
            if (frame_valid && !is_nonce) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = TX_IDLE;
               if (rsp_ok) begin
                  ack_ok_nxt = 1'b1;
                  if (is_info)
                     info_data_nxt = payload;
               end else begin
                  nak_nxt = 1'b1;
               end
            end else if (tcnt == TIMEOUT_CYCLES - 24'd1) begin
               done_nxt    = 1'b1;
               timeout_nxt = 1'b1;
               busy_nxt    = 1'b0;
               state_nxt   = TX_IDLE;
            end else begin
               tcnt_nxt = tcnt + 24'd1;
            end
         end
         default: state_nxt = TX_IDLE;
      endcase

      // Emit the top byte; the strobe also arms the one-cycle guard.
      if (try_send) begin
         transmit_nxt = 1'b1;
         tx_byte_nxt  = shreg_nxt[FRAME_W-1 -: 8];
         shreg_nxt    = {shreg_nxt[FRAME_W-9:0], 8'h00};
         cnt_nxt      = cnt_nxt - 6'd1;
         if (cnt_nxt == 6'd0) begin
            state_nxt = TX_WAIT;
            tcnt_nxt  = '0;
         end
      end
      guard_nxt = transmit_nxt;
   end

endmodule

// File: tb/tb_uart_job_dispatcher.sv
// Self-checking bench: UART core model, byte-level frame model, table of
// request/response scenarios plus hand-written NONCE, busy and reset sequences.
`timescale 1ns/1ps
module tb_uart_job_dispatcher;

   localparam logic [23:0] TMO     = 24'd100;
   localparam int          TMO_CYC = 100;

   logic         sys_clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_push = 1'b0;
   logic         req_info = 1'b0;
   logic [255:0] job_midstate = '0;
   logic [95:0]  job_data = '0;
   logic [31:0]  job_nonce_min = '0;
   logic [31:0]  job_nonce_max = '0;
   logic         transmit;
   logic [7:0]   tx_byte;
   logic         is_transmitting = 1'b0;
   logic         received = 1'b0;
   logic [7:0]   rx_byte = '0;
   logic         busy, done, ack_ok, nak, timeout, nonce_valid;
   logic [63:0]  info_data;
   logic [31:0]  nonce;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          tx_cnt = 0, first_tx_cyc = 0, last_tx_cyc = 0, uart_hold = 0;
   int          done_cnt = 0;
   logic [7:0]  tx_q[$];
   logic [7:0]  exp_q[$];
   logic [63:0] info_model = '0;

   typedef struct {
      bit         is_push;
      bit         reply;
      logic [7:0] rtype;
      logic [7:0] rlen;
      int         exp_res;   // 0 ack_ok, 1 nak, 2 timeout
   } vec_t;
   vec_t vecs[10];

   uart_job_dispatcher #(.TIMEOUT_CYCLES(TMO)) dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .req_push        (req_push),
      .req_info        (req_info),
      .job_midstate    (job_midstate),
      .job_data        (job_data),
      .job_nonce_min   (job_nonce_min),
      .job_nonce_max   (job_nonce_max),
      .transmit        (transmit),
      .tx_byte         (tx_byte),
      .is_transmitting (is_transmitting),
      .received        (received),
      .rx_byte         (rx_byte),
      .busy            (busy),
      .done            (done),
      .ack_ok          (ack_ok),
      .nak             (nak),
      .timeout         (timeout),
      .info_data       (info_data),
      .nonce_valid     (nonce_valid),
      .nonce           (nonce)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // UART core model: captures strobes, stays busy for 1..4 cycles afterwards.
   always @(negedge sys_clk) begin
      if (done) done_cnt++;
      if (transmit) begin
         n_checks++;
         if (is_transmitting) begin
            n_fail++;
            $display("FAIL strobe_guard: transmit=1 while is_transmitting=1 at cycle %0d", cyc);
         end
         tx_q.push_back(tx_byte);
         tx_cnt++;
         last_tx_cyc = cyc;
         if (tx_q.size() == 1) first_tx_cyc = cyc;
         is_transmitting = 1'b1;
         uart_hold = int'($urandom_range(4, 1));
      end else if (uart_hold > 0) begin
         uart_hold--;
         if (uart_hold == 0) is_transmitting = 1'b0;
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic put_byte(input logic [7:0] b);
      repeat ($urandom_range(2, 0)) @(negedge sys_clk);
      @(negedge sys_clk);
      received = 1'b1;
      rx_byte  = b;
      @(negedge sys_clk);
      received = 1'b0;
   endtask

   task automatic wait_tx(input int n);
      int t = 0;
      while (tx_q.size() < n && t < 2000) begin
         @(negedge sys_clk);
         t++;
      end
   endtask

   // Expected request bytes derived from the frame format: header, fields MSB first, pad.
   task automatic model_tx(input bit is_push, input logic [255:0] ms, input logic [95:0] dt,
                           input logic [31:0] nmin, input logic [31:0] nmax);
      exp_q.delete();
      exp_q.push_back(is_push ? 8'd60 : 8'd8);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(is_push ? 8'd2 : 8'd0);
      if (is_push) begin
         for (int i = 31; i >= 0; i--) exp_q.push_back(ms[i*8 +: 8]);
         for (int i = 11; i >= 0; i--) exp_q.push_back(dt[i*8 +: 8]);
         for (int i = 3; i >= 0; i--)  exp_q.push_back(nmin[i*8 +: 8]);
         for (int i = 3; i >= 0; i--)  exp_q.push_back(nmax[i*8 +: 8]);
      end
      repeat (4) exp_q.push_back(8'h00);
   endtask

   task automatic send_nonce(input logic [31:0] v);
      logic [7:0] f[$];
      f.push_back(8'h0C); f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h03);
      repeat (4) f.push_back(8'h00);
      for (int i = 3; i >= 0; i--) f.push_back(v[i*8 +: 8]);
      foreach (f[i]) put_byte(f[i]);
   endtask

   task automatic run_req(input string nm, input bit is_push, input logic [255:0] ms,
                          input logic [95:0] dt, input logic [31:0] nmin, input logic [31:0] nmax,
                          input bit reply, input logic [7:0] rtype, input logic [7:0] rlen,
                          input logic [63:0] rinfo, input int exp_res,
                          input bit inject_nonce, input bit poke);
      int acc_cyc, t, bad, n_exp, dc0;
      logic [7:0] rsp[$];
      model_tx(is_push, ms, dt, nmin, nmax);
      n_exp = exp_q.size();
      t = 0;
      while ((busy || is_transmitting) && t < 1000) begin @(negedge sys_clk); t++; end
      @(negedge sys_clk);
      tx_q.delete();
      dc0 = done_cnt;
      job_midstate = ms; job_data = dt; job_nonce_min = nmin; job_nonce_max = nmax;
      if (is_push) req_push = 1'b1; else req_info = 1'b1;
      acc_cyc = cyc;
      @(negedge sys_clk);
      req_push = 1'b0; req_info = 1'b0;
      check({nm, "_busy_rise"}, 64'(busy), 64'd1);
      if (poke) begin
         wait_tx(3);
         @(negedge sys_clk); req_push = 1'b1; req_info = 1'b1;
         @(negedge sys_clk); req_push = 1'b0; req_info = 1'b0;
      end
      if (inject_nonce) begin
         wait_tx(5);
         send_nonce(32'h12345678);
         check({nm, "_nonce_valid"}, 64'(nonce_valid), 64'd1);
         check({nm, "_nonce"}, 64'(nonce), 64'h12345678);
         check({nm, "_busy_during_send"}, 64'(busy), 64'd1);
         check({nm, "_no_done_on_nonce"}, 64'(done_cnt - dc0), 64'd0);
      end
      wait_tx(n_exp);
      if (tx_q.size() < n_exp) begin
         n_checks++; n_fail++;
         $display("FAIL %s_tx_len: got %0d bytes, expected %0d", nm, tx_q.size(), n_exp);
         return;
      end
      bad = -1;
      for (int i = 0; i < n_exp; i++) if (bad < 0 && tx_q[i] !== exp_q[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s_tx_byte: byte %0d got %02h, expected %02h", nm, bad, tx_q[bad], exp_q[bad]);
      end
      check({nm, "_first_strobe_lat"}, 64'(first_tx_cyc - acc_cyc), 64'd1);
      if (reply) begin
         rsp.push_back(rlen); rsp.push_back(8'h00); rsp.push_back(8'h00); rsp.push_back(rtype);
         for (int k = 4; k < int'(rlen); k++)
            rsp.push_back(k < 8 ? 8'h00 : rinfo[(int'(rlen) - 1 - k)*8 +: 8]);
         put_byte(8'h00);   // pong byte, must be ignored
         foreach (rsp[i]) put_byte(rsp[i]);
      end else begin
         t = 0;
         while (!done && t < TMO_CYC + 50) begin @(negedge sys_clk); t++; end
         check({nm, "_timeout_lat"}, 64'(cyc - last_tx_cyc), 64'(TMO_CYC));
      end
      check({nm, "_done"}, 64'(done), 64'd1);
      check({nm, "_ack_ok"}, 64'(ack_ok), 64'(exp_res == 0));
      check({nm, "_nak"}, 64'(nak), 64'(exp_res == 1));
      check({nm, "_timeout"}, 64'(timeout), 64'(exp_res == 2));
      check({nm, "_busy_fall"}, 64'(busy), 64'd0);
      if (exp_res == 0 && !is_push) info_model = rinfo;
      check({nm, "_info_data"}, info_data, info_model);
      repeat (10) @(negedge sys_clk);
      check({nm, "_tx_total"}, 64'(tx_q.size()), 64'(n_exp));
      check({nm, "_done_count"}, 64'(done_cnt - dc0), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] ms;
      logic [95:0]  dt;
      int           tx0, dn0;

      vecs[0] = '{1'b1, 1'b1, 8'd4, 8'd8,  0};
      vecs[1] = '{1'b0, 1'b1, 8'd0, 8'd16, 0};
      vecs[2] = '{1'b1, 1'b1, 8'd1, 8'd8,  1};
      vecs[3] = '{1'b0, 1'b1, 8'd1, 8'd8,  1};
      vecs[4] = '{1'b1, 1'b1, 8'd0, 8'd16, 1};
      vecs[5] = '{1'b0, 1'b1, 8'd4, 8'd8,  1};
      vecs[6] = '{1'b1, 1'b1, 8'd4, 8'd9,  1};
      vecs[7] = '{1'b0, 1'b1, 8'd0, 8'd12, 1};
      vecs[8] = '{1'b1, 1'b0, 8'd0, 8'd0,  2};
      vecs[9] = '{1'b0, 1'b0, 8'd0, 8'd0,  2};

      repeat (3) @(negedge sys_clk);
      check("rst_transmit", 64'(transmit), 64'd0);
      check("rst_tx_byte", 64'(tx_byte), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'({done, ack_ok, nak, timeout}), 64'd0);
      check("rst_info_data", info_data, 64'd0);
      check("rst_nonce", 64'({nonce_valid, nonce}), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      dt = {12{8'hA5}};
      run_req("push_ref", 1'b1, 256'h1, dt, 32'h0, 32'hFFFF_FFFF,
              1'b1, 8'd4, 8'd8, 64'h0, 0, 1'b0, 1'b0);
      run_req("info_ref", 1'b0, '0, '0, '0, '0,
              1'b1, 8'd0, 8'd16, 64'hDEADBEEF13370D13, 0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) ms[k*32 +: 32] = $urandom;
      dt = {$urandom, $urandom, $urandom};
      run_req("nonce_in_send", 1'b1, ms, dt, $urandom, $urandom,
              1'b1, 8'd4, 8'd8, 64'h0, 0, 1'b1, 1'b0);
      run_req("req_while_busy", 1'b1, ms, dt, $urandom, $urandom,
              1'b1, 8'd1, 8'd8, 64'h0, 1, 1'b0, 1'b1);

      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 8; k++) ms[k*32 +: 32] = $urandom;
         dt = {$urandom, $urandom, $urandom};
         run_req($sformatf("vec%0d", i), vecs[i].is_push, ms, dt, $urandom, $urandom,
                 vecs[i].reply, vecs[i].rtype, vecs[i].rlen, {$urandom, $urandom},
                 vecs[i].exp_res, 1'b0, 1'b0);
      end

      // Reset in the middle of a PUSH_JOB, with a response frame half received.
      for (int k = 0; k < 8; k++) ms[k*32 +: 32] = $urandom;
      @(negedge sys_clk);
      tx_q.delete();
      job_midstate = ms; req_push = 1'b1;
      @(negedge sys_clk);
      req_push = 1'b0;
      wait_tx(20);
      put_byte(8'h0C); put_byte(8'h00); put_byte(8'h00);
      @(negedge sys_clk); rst = 1'b1;
      @(negedge sys_clk); rst = 1'b0;
      tx0 = tx_cnt; dn0 = done_cnt;
      info_model = '0;
      check("abort_transmit", 64'(transmit), 64'd0);
      check("abort_tx_byte", 64'(tx_byte), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_flags", 64'({done, ack_ok, nak, timeout, nonce_valid}), 64'd0);
      check("abort_info_data", info_data, 64'd0);
      check("abort_nonce", 64'(nonce), 64'd0);
      repeat (200) @(negedge sys_clk);
      check("abort_no_transmit", 64'(tx_cnt - tx0), 64'd0);
      check("abort_no_done", 64'(done_cnt - dn0), 64'd0);
      send_nonce(32'hCAFEF00D);
      check("post_rst_nonce_valid", 64'(nonce_valid), 64'd1);
      check("post_rst_nonce", 64'(nonce), 64'hCAFEF00D);
      run_req("post_rst_info", 1'b0, '0, '0, '0, '0,
              1'b1, 8'd0, 8'd16, {$urandom, $urandom}, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
